// File: rtl/bram_tdp_ctrl.sv
// True dual-port BRAM controller: byte lanes, write-first merge, post-reset clear.
// Define BRAM_TDP_CTRL_OUTREG_EN for an extra output register stage per port.
module bram_tdp_ctrl #(
  parameter int DATA = 72,
  parameter int ADDR = 10,
  parameter int LANE = 8,
  parameter logic [LANE-1:0] CLR_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   init_done,
  input  logic                   a_req,
  output logic                   a_ready,
  input  logic                   a_wr,
  input  logic [DATA/LANE-1:0]   a_be,
  input  logic [ADDR-1:0]        a_addr,
  input  logic [DATA-1:0]        a_din,
  output logic                   a_rvalid,
  output logic [DATA-1:0]        a_dout,
  input  logic                   b_req,
  output logic                   b_ready,
  input  logic                   b_wr,
  input  logic [DATA/LANE-1:0]   b_be,
  input  logic [ADDR-1:0]        b_addr,
  input  logic [DATA-1:0]        b_din,
  output logic                   b_rvalid,
  output logic [DATA-1:0]        b_dout
);
  localparam int NLANE = DATA / LANE;
  localparam int DEPTH = 1 << ADDR;
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [ADDR-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA-1:0] mem [DEPTH];

  logic            run, clear;
  logic            a_re, a_we, b_re, b_we;
  logic            wa_en;
  logic [NLANE-1:0] wa_be;
  logic [ADDR-1:0] wa_addr;
  logic [DATA-1:0] wa_data;
  logic [DATA-1:0] a_merge, b_merge;

  logic            a_rvalid_q, a_rvalid_d;
  logic            b_rvalid_q, b_rvalid_d;
  logic [DATA-1:0] a_dout_q, a_dout_d;
  logic [DATA-1:0] b_dout_q, b_dout_d;

  assign run       = (state_q == S_RUN);
  assign clear     = (state_q == S_CLEAR);
  assign init_done = run;
  assign a_ready   = run;
  assign b_ready   = run;

  assign a_re = a_req & run & ~a_wr;
  assign a_we = a_req & run & a_wr;
  assign b_re = b_req & run & ~b_wr;
  assign b_we = b_req & run & b_wr;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Port A's write path doubles as the clear engine while clearing.
  assign wa_en   = clear | a_we;
  assign wa_be   = clear ? '1 : a_be;
  assign wa_addr = clear ? clr_cnt_q : a_addr;
  assign wa_data = clear ? {NLANE{CLR_VAL}} : a_din;

  // B is applied after A so B wins on overlapping lanes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NLANE; i++) begin
      if (wa_en && wa_be[i])
        mem[wa_addr][i*LANE +: LANE] <= wa_data[i*LANE +: LANE];
      if (b_we && b_be[i])
        mem[b_addr][i*LANE +: LANE] <= b_din[i*LANE +: LANE];
    end
  end

  always_comb begin
    a_merge = mem[a_addr];
    b_merge = mem[b_addr];
    for (int i = 0; i < NLANE; i++) begin
      if (b_we && b_be[i] && (b_addr == a_addr))
        a_merge[i*LANE +: LANE] = b_din[i*LANE +: LANE];
      if (a_we && a_be[i] && (a_addr == b_addr))
        b_merge[i*LANE +: LANE] = a_din[i*LANE +: LANE];
    end
  end

  always_comb begin
    a_rvalid_d = a_re;
    b_rvalid_d = b_re;
    a_dout_d   = a_re ? a_merge : a_dout_q;
    b_dout_d   = b_re ? b_merge : b_dout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_dout_q   <= '0;
      b_dout_q   <= '0;
    end else begin
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_dout_q   <= a_dout_d;
      b_dout_q   <= b_dout_d;
    end
  end

`ifdef BRAM_TDP_CTRL_OUTREG_EN
  logic            a_rv2_q, a_rv2_d;
  logic            b_rv2_q, b_rv2_d;
  logic [DATA-1:0] a_do2_q, a_do2_d;
  logic [DATA-1:0] b_do2_q, b_do2_d;

  always_comb begin
    a_rv2_d = a_rvalid_q;
    b_rv2_d = b_rvalid_q;
    a_do2_d = a_rvalid_q ? a_dout_q : a_do2_q;
    b_do2_d = b_rvalid_q ? b_dout_q : b_do2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rv2_q <= 1'b0;
      b_rv2_q <= 1'b0;
      a_do2_q <= '0;
      b_do2_q <= '0;
    end else begin
      a_rv2_q <= a_rv2_d;
      b_rv2_q <= b_rv2_d;
      a_do2_q <= a_do2_d;
      b_do2_q <= b_do2_d;
    end
  end

  assign a_rvalid = a_rv2_q;
  assign b_rvalid = b_rv2_q;
  assign a_dout   = a_do2_q;
  assign b_dout   = b_do2_q;
`else
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_dout   = a_dout_q;
  assign b_dout   = b_dout_q;
`endif
endmodule

// File: tb/tb_bram_tdp_ctrl.sv
// Scoreboard bench for bram_tdp_ctrl: directed vectors, queued
// expectations checked by a monitor on every rvalid.
module tb_bram_tdp_ctrl;
`ifdef BRAM_TDP_CTRL_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 0;
  logic        rst_n;
  logic        init_done;
  logic        a_req, a_ready, a_wr, a_rvalid;
  logic [8:0]  a_be;
  logic [9:0]  a_addr;
  logic [71:0] a_din, a_dout;
  logic        b_req, b_ready, b_wr, b_rvalid;
  logic [8:0]  b_be;
  logic [9:0]  b_addr;
  logic [71:0] b_din, b_dout;

  typedef struct {
    logic [71:0] d;
    int          c;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n;

  bram_tdp_ctrl dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .a_req(a_req), .a_ready(a_ready), .a_wr(a_wr), .a_be(a_be),
    .a_addr(a_addr), .a_din(a_din), .a_rvalid(a_rvalid), .a_dout(a_dout),
    .b_req(b_req), .b_ready(b_ready), .b_wr(b_wr), .b_be(b_be),
    .b_addr(b_addr), .b_din(b_din), .b_rvalid(b_rvalid), .b_dout(b_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [71:0] act, logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_rvalid) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_rvalid", 72'd1, 72'd0);
      end else begin
        e = qa.pop_front();
        chk("a_rd_data", a_dout, e.d);
        chk("a_rd_cycle", 72'(cyc), 72'(e.c));
      end
    end
    if (b_rvalid) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_rvalid", 72'd1, 72'd0);
      end else begin
        e = qb.pop_front();
        chk("b_rd_data", b_dout, e.d);
        chk("b_rd_cycle", 72'(cyc), 72'(e.c));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    a_req = 0; a_wr = 0; a_be = '0; a_addr = '0; a_din = '0;
    b_req = 0; b_wr = 0; b_be = '0; b_addr = '0; b_din = '0;
  endtask

  task automatic set_a(logic wr, logic [8:0] be, logic [9:0] ad,
                       logic [71:0] din);
    a_req = 1; a_wr = wr; a_be = be; a_addr = ad; a_din = din;
  endtask

  task automatic set_b(logic wr, logic [8:0] be, logic [9:0] ad,
                       logic [71:0] din);
    b_req = 1; b_wr = wr; b_be = be; b_addr = ad; b_din = din;
  endtask

  task automatic rd_a(logic [9:0] ad, logic [71:0] exp);
    set_a(0, '0, ad, '0);
    qa.push_back('{exp, cyc + LAT});
  endtask

  task automatic rd_b(logic [9:0] ad, logic [71:0] exp);
    set_b(0, '0, ad, '0);
    qb.push_back('{exp, cyc + LAT});
  endtask

  task automatic step;
    tick;
    idle;
  endtask

  task automatic wait_init(output int cnt);
    cnt = 0;
    while (!init_done && cnt < 2000) begin
      tick;
      cnt++;
    end
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_init_done"}, 72'(init_done), 72'd0);
    chk({tag, "_ready"}, 72'({a_ready, b_ready}), 72'd0);
    chk({tag, "_rvalid"}, 72'({a_rvalid, b_rvalid}), 72'd0);
    chk({tag, "_a_dout"}, a_dout, 72'd0);
    chk({tag, "_b_dout"}, b_dout, 72'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    idle;
    repeat (3) tick;
    chk_reset_outs("rst");

    // Read held during reset and the whole clear must be ignored.
    rd_a(10'd0, 72'd0);
    void'(qa.pop_back());
    rst_n = 1;
    wait_init(n);
    idle;
    chk("clear_cycles", 72'(n), 72'd1024);
    chk("ready_run", 72'({a_ready, b_ready}), 72'b11);

    rd_a(10'd0, 72'd0); rd_b(10'd511, 72'd0); step;
    rd_a(10'd1023, 72'd0); step;

    set_a(1, 9'h1FF, 10'd5, {72{1'b1}}); step;
    set_b(1, 9'h003, 10'd5, 72'd0); step;
    rd_a(10'd5, 72'hFF_FFFF_FFFF_FFFF_0000);
    rd_b(10'd5, 72'hFF_FFFF_FFFF_FFFF_0000); step;
    set_a(1, 9'h000, 10'd5, 72'd0); step;
    rd_b(10'd5, 72'hFF_FFFF_FFFF_FFFF_0000); step;

    set_a(1, 9'h1FF, 10'd7, {9{8'h11}});
    set_b(1, 9'h0F0, 10'd7, {9{8'h22}}); step;
    rd_a(10'd7, 72'h11_2222_2222_1111_1111); step;

    rd_a(10'd9, 72'h00_0000_0000_0000_00AB);
    set_b(1, 9'h001, 10'd9, {9{8'hAB}}); step;
    set_a(1, 9'h100, 10'd9, {9{8'hCD}});
    rd_b(10'd9, 72'hCD_0000_0000_0000_00AB); step;
    rd_a(10'd9, 72'hCD_0000_0000_0000_00AB); step;

    set_a(1, 9'h1FF, 10'd10, 72'h12_3456_789A_BCDE_F012); step;
    rd_a(10'd10, 72'h12_3456_789A_BCDE_F012); step;

    set_a(1, 9'h1FF, 10'd20, {9{8'h5A}});
    rd_b(10'd21, 72'd0); step;

    for (int i = 0; i < 4; i++) begin
      set_a(1, 9'h1FF, 10'(30 + i), 72'(i * 72'h1111 + 72'h7));
      step;
    end
    for (int i = 0; i < 4; i++) begin
      rd_a(10'(30 + i), 72'(i * 72'h1111 + 72'h7));
      tick;
    end
    idle;
    repeat (4) tick;
    chk("drain1", 72'(qa.size() + qb.size()), 72'd0);

    rst_n = 0;
    #1;
    chk_reset_outs("rst_run");
    tick;
    rst_n = 1;
    repeat (300) tick;
    rst_n = 0;
    #1;
    chk_reset_outs("rst_clr");
    tick;
    rst_n = 1;
    wait_init(n);
    chk("reclear_cycles", 72'(n), 72'd1024);

    rd_a(10'd5, 72'd0); rd_b(10'd7, 72'd0); step;
    rd_a(10'd10, 72'd0); step;
    repeat (4) tick;
    chk("drain2", 72'(qa.size() + qb.size()), 72'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bram_tdp_ctrl.md
Name: bram_tdp_ctrl

Overview:
- Parametrised controller around a true dual-port block RAM.
- Two independent request ports, A and B. Each port can read or write on any cycle.
- Adds byte-lane write enables, a defined read-during-write policy and a hardware clear of the whole array after reset.
- Sits between the core's load/store and fetch paths and the memory array, and replaces direct instantiation of the bare dual-port RAM.

Parameters:
- DATA, 72, data word width in bits; must be a multiple of LANE.
- ADDR, 10, address width; depth is 2^ADDR words.
- LANE, 8, bits per byte-enable lane; NLANE = DATA/LANE.
- CLR_VAL, 0, value written to every lane during the post-reset clear.

Ports:
- clk  in  1  single clock for both ports and the array.
- rst_n  in  1  asynchronous active-low reset.
- init_done  out  1  high once the post-reset clear has finished.
- a_req  in  1  port A request valid.
- a_ready  out  1  port A can accept a request (equals init_done).
- a_wr  in  1  1 = write, 0 = read.
- a_be  in  NLANE  lane write enables; ignored on reads.
- a_addr  in  ADDR  word address.
- a_din  in  DATA  write data.
- a_rvalid  out  1  a_dout carries read data this cycle.
- a_dout  out  DATA  read data; holds its last value between reads.
- b_req, b_ready, b_wr, b_be, b_addr, b_din, b_rvalid, b_dout: same as port A, for port B.

Behaviour:
- Reset, asynchronous while rst_n=0:
  - init_done=0; a_ready=b_ready=0; a_rvalid=b_rvalid=0; a_dout=b_dout=0.
  - Clear counter=0; FSM enters CLEAR.
- FSM states: CLEAR, RUN.
  - CLEAR: each cycle, write CLEAR_VAL (all lanes) to address clr_cnt, then increment clr_cnt.
  - After writing address 2^ADDR-1, go to RUN. The clear takes exactly 2^ADDR cycles from rst_n rising.
  - RUN: init_done=1; both ports ready. RUN has no exit except reset.
- Reset during CLEAR restarts the clear at address 0. Reset during RUN does not clear the array until the new CLEAR pass runs.
- Requests while ready=0 are ignored: no array access and no rvalid.
- A request is accepted when req & ready.
- Accepted read: x_rvalid=1 and x_dout = word at the next rising edge (latency 1).
- Accepted write:
  - Lanes with x_be[i]=1 are updated; all other lanes keep their contents.
  - Writes never assert rvalid. be=0 is a legal no-op write.
- rvalid is high for exactly one cycle per accepted read. Back-to-back reads give rvalid on consecutive cycles.
- Read-after-write on consecutive cycles, same or opposite port, returns the written data.
- Same-cycle collisions in RUN, same address:
  - Both ports write: per lane, B's value wins where b_be=1; A's value lands where only a_be=1.
  - One port reads, the other writes: write-first. The read returns the old word with the enabled lanes replaced by the new data, merged per lane.
  - Both ports read: both return the stored word.
- Different addresses never interact.
- Addresses are exactly ADDR bits; there is no wrap or range check beyond the port width.

Optional Feature:
- Macro: BRAM_TDP_CTRL_OUTREG_EN.
- When defined:
  - An extra output register stage is added on each port.
  - Read latency is 2: rvalid and dout are both delayed one more cycle.
  - Pipelined reads are still accepted every cycle.
  - The collision merge result is the value that gets registered.
- When undefined: read latency is 1, as described in Behaviour.
- Reset clears the extra stage registers to 0.

Test Plan:
- Clear: release rst_n, hold a_req=b_req=0 -> init_done rises exactly 1024 cycles later. Then read addresses 0, 511 and 1023 -> all return 0.
- Byte enables: A writes 72'hFF_FFFF_FFFF_FFFF_FFFF to address 5 with be=9'h1FF. Then B writes 0 to address 5 with be=9'h003 -> reading address 5 returns 72'hFF_FFFF_FFFF_FFFF_0000.
- Write/write collision: A writes 72'h11..11 and B writes 72'h22..22 to address 7 in the same cycle, a_be=9'h1FF, b_be=9'h0F0 -> address 7 holds lanes 4-7 = 8'h22 and the other lanes = 8'h11.
- Read/write collision:
  - A reads address 9 (holding 0) while B writes 72'hAB..AB with be=9'h001 in the same cycle.
  - -> a_dout = 72'h00..00AB with a_rvalid=1 one cycle later (two cycles later with BRAM_TDP_CTRL_OUTREG_EN).
- Reset mid-clear: pulse rst_n low at clear cycle 300 -> outputs zero immediately, and init_done rises 1024 cycles after the release.
- Gating: assert a_req with a read while init_done=0 -> no a_rvalid, ever. Four back-to-back reads in RUN -> four consecutive a_rvalid pulses in order.
